// File: rtl/vend_kiosk_arbiter.sv
// Two-kiosk arbiter for a shared vending core: round-robin session grant, timeout, forced drain.
// Optional ARB_STATS_EN adds saturating per-kiosk vend counters VEND_CNT0/VEND_CNT1.
module vend_kiosk_arbiter #(
  parameter int TIMEOUT   = 64,
  parameter int DRAIN_CYC = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [1:0] K_CARD_IN,
  input  logic [1:0] K_KEY_PRESS,
  input  logic [7:0] K_ITEM_CODE,
  input  logic [1:0] K_VALID_TRAN,
  input  logic [1:0] K_DOOR_OPEN,
  output logic       M_CARD_IN,
  output logic       M_KEY_PRESS,
  output logic       M_VALID_TRAN,
  output logic       M_DOOR_OPEN,
  output logic [3:0] M_ITEM_CODE,
  input  logic       M_VEND,
  input  logic       M_INVALID_SEL,
  input  logic       M_FAILED_TRAN,
  input  logic [2:0] M_COST,
  output logic [1:0] GNT,
  output logic [1:0] K_VEND,
  output logic [1:0] K_INVALID_SEL,
  output logic [1:0] K_FAILED_TRAN,
  output logic [2:0] K_COST,
  output logic       BUSY
`ifdef ARB_STATS_EN
  ,
  output logic [7:0] VEND_CNT0,
  output logic [7:0] VEND_CNT1
`endif
);

  typedef enum logic [1:0] {IDLE, SESSION, DRAIN} state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);
  localparam logic [3:0] DRN_LOAD = 4'(DRAIN_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       own_q, own_d;
  logic       last_q, last_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] drain_q, drain_d;
  logic       vend_q, vend_d;
  logic       inv_q, inv_d;
  logic       fail_q, fail_d;
  logic       inv_lat_q, inv_lat_d;
  logic       fail_lat_q, fail_lat_d;

  logic in_sess, inv_rise, fail_rise, vend_fall, sess_end;

  assign in_sess   = (state_q == SESSION);
  assign inv_rise  = M_INVALID_SEL & ~inv_q;
  assign fail_rise = M_FAILED_TRAN & ~fail_q;
  assign vend_fall = vend_q & ~M_VEND;
  // All end causes collapse into one event, so coincident causes give a single drain.
  assign sess_end  = in_sess & (inv_rise | fail_rise | vend_fall | ~REQ[own_q] | (timer_q == 8'd0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      own_q      <= 1'b0;
      last_q     <= 1'b1;
      timer_q    <= 8'd0;
      drain_q    <= 4'd0;
      vend_q     <= 1'b0;
      inv_q      <= 1'b0;
      fail_q     <= 1'b0;
      inv_lat_q  <= 1'b0;
      fail_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      own_q      <= own_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      drain_q    <= drain_d;
      vend_q     <= vend_d;
      inv_q      <= inv_d;
      fail_q     <= fail_d;
      inv_lat_q  <= inv_lat_d;
      fail_lat_q <= fail_lat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    own_d      = own_q;
    last_d     = last_q;
    timer_d    = timer_q;
    drain_d    = drain_q;
    vend_d     = 1'b0;
    inv_d      = 1'b0;
    fail_d     = 1'b0;
    inv_lat_d  = inv_lat_q;
    fail_lat_d = fail_lat_q;
    case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          state_d = SESSION;
          own_d   = (REQ == 2'b11) ? ~last_q : REQ[1];
          gnt_d   = own_d ? 2'b10 : 2'b01;
          timer_d = TMR_LOAD;
        end
      end
      SESSION: begin
        vend_d = M_VEND;
        inv_d  = M_INVALID_SEL;
        fail_d = M_FAILED_TRAN;
        if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
        if (sess_end) begin
          state_d    = DRAIN;
          gnt_d      = 2'b00;
          drain_d    = DRN_LOAD;
          inv_lat_d  = inv_rise;
          fail_lat_d = fail_rise;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d    = IDLE;
          last_d     = own_q;
          inv_lat_d  = 1'b0;
          fail_lat_d = 1'b0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic gate;
  assign gate = in_sess & gnt_q[own_q];

  always_comb begin
    M_CARD_IN     = gate & K_CARD_IN[own_q];
    M_KEY_PRESS   = gate & K_KEY_PRESS[own_q];
    M_VALID_TRAN  = gate & K_VALID_TRAN[own_q];
    M_DOOR_OPEN   = gate & K_DOOR_OPEN[own_q];
    M_ITEM_CODE   = gate ? (own_q ? K_ITEM_CODE[7:4] : K_ITEM_CODE[3:0]) : 4'h0;
    K_VEND        = 2'b00;
    K_INVALID_SEL = 2'b00;
    K_FAILED_TRAN = 2'b00;
    K_COST        = in_sess ? M_COST : 3'd0;
    if (in_sess) begin
      K_VEND[own_q]        = M_VEND;
      K_INVALID_SEL[own_q] = M_INVALID_SEL;
      K_FAILED_TRAN[own_q] = M_FAILED_TRAN;
    end else if (state_q == DRAIN) begin
      K_INVALID_SEL[own_q] = inv_lat_q;
      K_FAILED_TRAN[own_q] = fail_lat_q;
    end
    GNT  = gnt_q;
    BUSY = (state_q != IDLE);
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic       vend_ev;
  assign vend_ev = in_sess & vend_fall;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (vend_ev && !own_q && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
    if (vend_ev &&  own_q && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign VEND_CNT0 = cnt0_q;
  assign VEND_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_vend_kiosk_arbiter.sv
// Directed bench for vend_kiosk_arbiter: grant, round-robin, latched results, timeout, reset.
module tb_vend_kiosk_arbiter;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] REQ, K_CARD_IN, K_KEY_PRESS, K_VALID_TRAN, K_DOOR_OPEN;
  logic [7:0] K_ITEM_CODE;
  logic       M_CARD_IN, M_KEY_PRESS, M_VALID_TRAN, M_DOOR_OPEN;
  logic [3:0] M_ITEM_CODE;
  logic       M_VEND, M_INVALID_SEL, M_FAILED_TRAN;
  logic [2:0] M_COST;
  logic [1:0] GNT, K_VEND, K_INVALID_SEL, K_FAILED_TRAN;
  logic [2:0] K_COST;
  logic       BUSY;
`ifdef ARB_STATS_EN
  logic [7:0] VEND_CNT0, VEND_CNT1;
`endif

  int errs = 0;
  int nchk = 0;

  vend_kiosk_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ),
    .K_CARD_IN(K_CARD_IN), .K_KEY_PRESS(K_KEY_PRESS), .K_ITEM_CODE(K_ITEM_CODE),
    .K_VALID_TRAN(K_VALID_TRAN), .K_DOOR_OPEN(K_DOOR_OPEN),
    .M_CARD_IN(M_CARD_IN), .M_KEY_PRESS(M_KEY_PRESS), .M_VALID_TRAN(M_VALID_TRAN),
    .M_DOOR_OPEN(M_DOOR_OPEN), .M_ITEM_CODE(M_ITEM_CODE),
    .M_VEND(M_VEND), .M_INVALID_SEL(M_INVALID_SEL), .M_FAILED_TRAN(M_FAILED_TRAN),
    .M_COST(M_COST), .GNT(GNT), .K_VEND(K_VEND), .K_INVALID_SEL(K_INVALID_SEL),
    .K_FAILED_TRAN(K_FAILED_TRAN), .K_COST(K_COST), .BUSY(BUSY)
`ifdef ARB_STATS_EN
    , .VEND_CNT0(VEND_CNT0), .VEND_CNT1(VEND_CNT1)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    REQ = 2'b00; K_CARD_IN = 2'b00; K_KEY_PRESS = 2'b00; K_VALID_TRAN = 2'b00;
    K_DOOR_OPEN = 2'b00; K_ITEM_CODE = 8'h00;
    M_VEND = 1'b0; M_INVALID_SEL = 1'b0; M_FAILED_TRAN = 1'b0; M_COST = 3'd0;
  endtask

  task automatic do_reset();
    idle_in();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
  endtask

  function automatic logic [31:0] m_bus();
    return {24'd0, M_CARD_IN, M_KEY_PRESS, M_VALID_TRAN, M_DOOR_OPEN, M_ITEM_CODE};
  endfunction

`ifdef ARB_STATS_EN
  task automatic vend_sess(input logic k);
    REQ = k ? 2'b10 : 2'b01;
    tick();
    M_VEND = 1'b1; tick();
    M_VEND = 1'b0; tick();
    REQ = 2'b00;
    repeat (4) tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_in();
    RESET = 1'b1;
    tick(); tick();
    // Reset state: inputs active but nothing may leak while in reset/IDLE
    K_CARD_IN = 2'b11; K_ITEM_CODE = 8'hFF; M_VEND = 1'b1; M_COST = 3'd7;
    #1;
    chk("rst_gnt", GNT, 2'b00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_mbus", m_bus(), 0);
    chk("rst_kvend", K_VEND, 2'b00);
    chk("rst_kcost", K_COST, 3'd0);
    idle_in();
    RESET = 1'b0;

    // T1: single request, input muxing, falling vend ends session, 4-cycle drain
    REQ = 2'b01; tick();
    chk("t1_gnt", GNT, 2'b01);
    chk("t1_busy", BUSY, 1'b1);
    K_CARD_IN = 2'b01; #1 chk("t1_mcard", M_CARD_IN, 1'b1);
    K_CARD_IN = 2'b10; #1 chk("t1_mcard_nonown", M_CARD_IN, 1'b0);
    K_CARD_IN = 2'b01; K_ITEM_CODE = 8'h5A; #1 chk("t1_item", M_ITEM_CODE, 4'hA);
    REQ = 2'b11; M_VEND = 1'b1; M_COST = 3'd5;
    #1 chk("t1_kvend", K_VEND, 2'b01);
    chk("t1_kcost", K_COST, 3'd5);
    tick();
    chk("t1_gnt_hold", GNT, 2'b01);
    M_VEND = 1'b0; REQ = 2'b01; #1 chk("t1_kvend0", K_VEND, 2'b00);
    tick();
    chk("t1_drain_gnt", GNT, 2'b00);
    chk("t1_drain_mbus", m_bus(), 0);
    chk("t1_drain_busy", BUSY, 1'b1);
    chk("t1_drain_kcost", K_COST, 3'd0);
    REQ = 2'b00;
    repeat (3) tick();
    chk("t1_drain_last", BUSY, 1'b1);
    tick();
    chk("t1_idle_busy", BUSY, 1'b0);

    // T2: both request from reset -> kiosk 0, then kiosk 1; failed tran latched in drain
    do_reset();
    REQ = 2'b11; tick();
    chk("t2_first_gnt", GNT, 2'b01);
    M_FAILED_TRAN = 1'b1; #1 chk("t2_kfail", K_FAILED_TRAN, 2'b01);
    tick();
    M_FAILED_TRAN = 1'b0; #1 chk("t2_fail_latched", K_FAILED_TRAN, 2'b01);
    repeat (3) tick();
    chk("t2_fail_latch_end", K_FAILED_TRAN, 2'b01);
    tick();
    chk("t2_idle_gnt", GNT, 2'b00);
    chk("t2_idle_kfail", K_FAILED_TRAN, 2'b00);
    tick();
    chk("t2_rr_gnt", GNT, 2'b10);

    // T3: invalid selection latched for owner 0 only, core inputs held low in drain
    do_reset();
    REQ = 2'b01; tick();
    K_CARD_IN = 2'b11; K_KEY_PRESS = 2'b11; K_VALID_TRAN = 2'b11; K_DOOR_OPEN = 2'b11;
    K_ITEM_CODE = 8'hFF;
    #1 chk("t3_mbus_sess", m_bus(), 32'hFF);
    M_INVALID_SEL = 1'b1; #1 chk("t3_kinv", K_INVALID_SEL, 2'b01);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_kinv_drain", K_INVALID_SEL, 2'b01);
      chk("t3_mbus_drain", m_bus(), 0);
      tick();
    end
    chk("t3_idle_kinv", K_INVALID_SEL, 2'b00);
    chk("t3_idle_busy", BUSY, 1'b0);

    // T4: owner 1 idle for full timeout
    do_reset();
    REQ = 2'b10; tick();
    n = 0;
    while (GNT == 2'b10 && n < 100) begin
      n++;
      tick();
    end
    chk("t4_len", n, 64);
    chk("t4_gnt", GNT, 2'b00);
    chk("t4_busy", BUSY, 1'b1);

    // T5: reset mid-session restores LAST=1 (kiosk 0 wins next tie)
    do_reset();
    REQ = 2'b01; tick();
    M_VEND = 1'b1; tick();
    M_VEND = 1'b0; tick();
    REQ = 2'b00;
    repeat (4) tick();
    REQ = 2'b10; tick();
    chk("t5_gnt", GNT, 2'b10);
    K_CARD_IN = 2'b10; tick(); tick();
    RESET = 1'b1; REQ = 2'b11; tick();
    chk("t5_rst_gnt", GNT, 2'b00);
    chk("t5_rst_busy", BUSY, 1'b0);
    chk("t5_rst_mcard", M_CARD_IN, 1'b0);
    RESET = 1'b0; tick();
    chk("t5_last", GNT, 2'b01);

    // T6: REQ drop together with invalid rise is a single end event
    do_reset();
    REQ = 2'b01; tick();
    REQ = 2'b00; M_INVALID_SEL = 1'b1; tick();
    chk("t6_drain_gnt", GNT, 2'b00);
    chk("t6_kinv", K_INVALID_SEL, 2'b01);
    repeat (3) tick();
    chk("t6_busy", BUSY, 1'b1);
    tick();
    chk("t6_idle", BUSY, 1'b0);

`ifdef ARB_STATS_EN
    do_reset();
    chk("st_rst0", VEND_CNT0, 8'd0);
    chk("st_rst1", VEND_CNT1, 8'd0);
    vend_sess(1'b0); vend_sess(1'b0); vend_sess(1'b0); vend_sess(1'b1);
    chk("st_cnt0", VEND_CNT0, 8'd3);
    chk("st_cnt1", VEND_CNT1, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/vend_kiosk_arbiter.md
Name: vend_kiosk_arbiter

Overview:
- Shares one vending-machine core between two customer kiosks (0 and 1), each with its own card reader, keypad and door sensor.
- Grants the core to one kiosk per session and muxes that kiosk's inputs to the core.
- Routes the core's result outputs back to the owning kiosk only.
- Enforces a session timeout and a drain gap that forces the core back to idle before the next grant.

Parameters:
- TIMEOUT, 64: maximum cycles a session may hold the grant (valid range 2..255).
- DRAIN_CYC, 4: cycles all core inputs are forced low after a session ends (valid range 1..15).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high
- REQ  in  2  per-kiosk session request; kiosk i holds REQ[i] high while a customer is present
- K_CARD_IN  in  2  per-kiosk card inserted
- K_KEY_PRESS  in  2  per-kiosk key strobe
- K_ITEM_CODE  in  8  kiosk 0 on [3:0], kiosk 1 on [7:4]
- K_VALID_TRAN  in  2  per-kiosk payment approved
- K_DOOR_OPEN  in  2  per-kiosk delivery door sensor
- M_CARD_IN, M_KEY_PRESS, M_VALID_TRAN, M_DOOR_OPEN  out  1 each  to core
- M_ITEM_CODE  out  4  to core
- M_VEND, M_INVALID_SEL, M_FAILED_TRAN  in  1 each  from core
- M_COST  in  3  from core
- GNT  out  2  one-hot-or-zero grant
- K_VEND, K_INVALID_SEL, K_FAILED_TRAN  out  2 each  per-kiosk results
- K_COST  out  3  cost for granted kiosk, 0 otherwise
- BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset values: state IDLE, GNT=0, all M_* outputs 0, all K_* outputs 0, BUSY=0, last-served pointer LAST=1 (kiosk 0 wins the first tie), timer and drain counter 0.
- IDLE:
  - If exactly one REQ bit is high, go to SESSION and grant that kiosk.
  - If both are high, grant the kiosk != LAST.
  - GNT is registered and asserts one cycle after REQ is sampled.
  - The timer loads TIMEOUT-1 on entry to SESSION.
- SESSION (owner g):
  - M_* follow the owner's K_* combinationally, gated by GNT[g].
  - K_VEND[g], K_INVALID_SEL[g], K_FAILED_TRAN[g] and K_COST follow the core combinationally; the non-owner's result bits are 0.
  - The timer decrements every cycle.
  - End conditions, evaluated every cycle, any of which moves the block to DRAIN on the next edge:
    - rising edge of M_INVALID_SEL or M_FAILED_TRAN
    - falling edge of M_VEND
    - REQ[g]=0
    - timer==0
  - Edge detection uses registered copies of M_VEND, M_INVALID_SEL and M_FAILED_TRAN; these copies are cleared on reset and on SESSION entry.
- DRAIN:
  - GNT=0 and all M_* forced to 0.
  - K_INVALID_SEL[g] and K_FAILED_TRAN[g] stay latched high for the drain period if they ended the session, so the kiosk can display them; all other K_* are 0.
  - The counter loads DRAIN_CYC-1 on entry and counts down to 0; at 0, set LAST=g and go to IDLE.
  - Requests arriving during DRAIN are held off, not lost; they are evaluated in IDLE.
- A REQ[g] drop in the same cycle as another end condition is a single end event; no double DRAIN.
- REQ of the non-owner during SESSION has no effect.
- RESET mid-session: the next cycle is IDLE with all outputs 0. No drain is performed; the core is reset by the same RESET.
- Timer width is 8 bits; drain counter width is 4 bits; neither wraps, since a transition happens at 0.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds output ports VEND_CNT0 and VEND_CNT1 (8 bits each).
  - VEND_CNT[g] increments on each M_VEND falling edge during a session owned by g.
  - Counters saturate at 255 and clear only on RESET.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then REQ=01:
  - GNT=01 one cycle later.
  - K_CARD_IN[0] pulse appears on M_CARD_IN.
  - M_VEND 1→0 gives DRAIN for 4 cycles, then IDLE with BUSY=0.
- REQ=11 from reset:
  - Kiosk 0 is granted first.
  - After its session ends and drain completes with REQ still 11, kiosk 1 is granted (round-robin).
- Owner 0, core raises M_INVALID_SEL:
  - K_INVALID_SEL=01 through 4 drain cycles.
  - K_INVALID_SEL[1] is never 1.
  - M_* are all 0 during drain.
- Owner 1 holds REQ with no core activity for 64 cycles: GNT drops at the timeout and the block enters DRAIN.
- RESET asserted mid-SESSION with GNT=10: next cycle GNT=0, M_*=0, BUSY=0, and LAST returns to 1.
- With ARB_STATS_EN: 3 vends by kiosk 0 and 1 by kiosk 1 give VEND_CNT0=3 and VEND_CNT1=1.
